sram_port_arbiter: RTL and testbench

- Round-robin arbiter that shares the single read/write port (port 0) of the banked 1RW SRAM wrapper between two requesters, A (instruction fetch) and B (load/store unit).
- Converts valid/ready requests into active-low csb/web strobes, tags each read with its owner, and routes the returned dout to that owner after a fixed read latency.
- Sits directly in front of the SRAM wrapper inside the core memory subsystem.

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/sram_arb_rr.sv | 29 ++
 rtl/sram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: owner tags, the request bundle and read-latency limit.
// Used by sram_port_arbiter and sram_arb_rr; SRAM_ARB_PERF_EN only affects the top level.
package sram_arb_pkg;

   localparam int MAX_READ_LAT   = 4;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 12;
   localparam int DEF_NUM_WMASKS = DEF_DATA_WIDTH / 8;

   typedef enum logic {
      OWN_A = 1'b0,
      OWN_B = 1'b1
   } owner_t;

   // Request bundle at the default bus widths.
   typedef struct packed {
      logic                      we;
      logic [DEF_NUM_WMASKS-1:0] wmask;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] wdata;
   } req_t;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way round-robin grant with a registered priority pointer.
// Pointer flips only on contested cycles; a lone requester never moves it.
module sram_arb_rr
   import sram_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic a_valid,
   input  logic b_valid,
   output logic grant_a,
   output logic grant_b
);

   owner_t ptr;

   always_comb begin
      grant_a = a_valid && (!b_valid || ptr == OWN_A);
      grant_b = b_valid && (!a_valid || ptr == OWN_B);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= OWN_A;
      end else if (a_valid && b_valid) begin
         ptr <= (ptr == OWN_A) ? OWN_B : OWN_A;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port 0 between requesters A and B: registered strobes, owner-tagged read return.
// Define SRAM_ARB_PERF_EN to add saturating grant/conflict counters.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_WMASKS = 4,
   parameter int READ_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   output logic                  a_ready,
   input  logic                  a_we,
   input  logic [NUM_WMASKS-1:0] a_wmask,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_valid,
   output logic                  b_ready,
   input  logic                  b_we,
   input  logic [NUM_WMASKS-1:0] b_wmask,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  sram_csb,
   output logic                  sram_web,
   output logic [NUM_WMASKS-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
`ifdef SRAM_ARB_PERF_EN
   ,
   output logic [31:0]           a_grant_cnt,
   output logic [31:0]           b_grant_cnt,
   output logic [31:0]           conflict_cnt
`endif
);

   if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_lat
      $error("sram_port_arbiter: READ_LAT out of range");
   end

   logic grant_a, grant_b;
   logic acc_a, acc_b;

   sram_arb_rr u_rr (
      .clk     (clk),
      .rst     (rst),
      .a_valid (a_valid),
      .b_valid (b_valid),
      .grant_a (grant_a),
      .grant_b (grant_b)
   );

   assign a_ready = grant_a;
   assign b_ready = grant_b;
   assign acc_a   = a_valid && grant_a;
   assign acc_b   = b_valid && grant_b;

   logic                  win_we;
   logic [NUM_WMASKS-1:0] win_wmask;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;
   owner_t                win_own;

   always_comb begin
      win_own   = acc_b ? OWN_B : OWN_A;
      win_we    = acc_b ? b_we    : a_we;
      win_wmask = acc_b ? b_wmask : a_wmask;
      win_addr  = acc_b ? b_addr  : a_addr;
      win_wdata = acc_b ? b_wdata : a_wdata;
   end

   // The issue tag travels alongside the strobes, so the tag pipeline starts at the SRAM sampling edge.
   logic   issue_vld;
   owner_t issue_own;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_csb   <= 1'b1;
         sram_web   <= 1'b1;
         sram_wmask <= '0;
         sram_addr  <= '0;
         sram_din   <= '0;
         issue_vld  <= 1'b0;
         issue_own  <= OWN_A;
      end else if (acc_a || acc_b) begin
         sram_csb   <= 1'b0;
         sram_web   <= ~win_we;
         sram_wmask <= win_wmask;
         sram_addr  <= win_addr;
         sram_din   <= win_wdata;
         issue_vld  <= ~win_we;
         issue_own  <= win_own;
      end else begin
         sram_csb   <= 1'b1;
         sram_web   <= 1'b1;
         issue_vld  <= 1'b0;
      end
   end

   logic [READ_LAT-1:0] tag_vld;
   owner_t              tag_own [READ_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld <= '0;
         for (int i = 0; i < READ_LAT; i++) tag_own[i] <= OWN_A;
      end else begin
         tag_vld[0] <= issue_vld;
         tag_own[0] <= issue_own;
         for (int i = 1; i < READ_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_own[i] <= tag_own[i-1];
         end
      end
   end

   logic ret_a, ret_b;
   assign ret_a = tag_vld[READ_LAT-1] && (tag_own[READ_LAT-1] == OWN_A);
   assign ret_b = tag_vld[READ_LAT-1] && (tag_own[READ_LAT-1] == OWN_B);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
         a_rdata  <= '0;
         b_rdata  <= '0;
      end else begin
         a_rvalid <= ret_a;
         b_rvalid <= ret_b;
         if (ret_a) a_rdata <= sram_dout;
         if (ret_b) b_rdata <= sram_dout;
      end
   end

`ifdef SRAM_ARB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_grant_cnt  <= '0;
         b_grant_cnt  <= '0;
         conflict_cnt <= '0;
      end else begin
         if (acc_a && a_grant_cnt != '1) a_grant_cnt <= a_grant_cnt + 32'd1;
         if (acc_b && b_grant_cnt != '1) b_grant_cnt <= b_grant_cnt + 32'd1;
         if (a_valid && b_valid && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural 1RW SRAM (READ_LAT = 1).
// Perf-counter checks are compiled in when SRAM_ARB_PERF_EN is defined.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0, a_ready, a_we = 1'b0;
   logic [3:0]  a_wmask = '0;
   logic [11:0] a_addr = '0;
   logic [31:0] a_wdata = '0;
   logic        a_rvalid;
   logic [31:0] a_rdata;
   logic        b_valid = 1'b0, b_ready, b_we = 1'b0;
   logic [3:0]  b_wmask = '0;
   logic [11:0] b_addr = '0;
   logic [31:0] b_wdata = '0;
   logic        b_rvalid;
   logic [31:0] b_rdata;
   logic        sram_csb, sram_web;
   logic [3:0]  sram_wmask;
   logic [11:0] sram_addr;
   logic [31:0] sram_din;
   logic [31:0] sram_dout = '0;
`ifdef SRAM_ARB_PERF_EN
   logic [31:0] a_grant_cnt, b_grant_cnt, conflict_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] mem [0:4095];

   sram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .NUM_WMASKS(4), .READ_LAT(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .a_valid    (a_valid),
      .a_ready    (a_ready),
      .a_we       (a_we),
      .a_wmask    (a_wmask),
      .a_addr     (a_addr),
      .a_wdata    (a_wdata),
      .a_rvalid   (a_rvalid),
      .a_rdata    (a_rdata),
      .b_valid    (b_valid),
      .b_ready    (b_ready),
      .b_we       (b_we),
      .b_wmask    (b_wmask),
      .b_addr     (b_addr),
      .b_wdata    (b_wdata),
      .b_rvalid   (b_rvalid),
      .b_rdata    (b_rdata),
      .sram_csb   (sram_csb),
      .sram_web   (sram_web),
      .sram_wmask (sram_wmask),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
`ifdef SRAM_ARB_PERF_EN
      ,
      .a_grant_cnt  (a_grant_cnt),
      .b_grant_cnt  (b_grant_cnt),
      .conflict_cnt (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: strobes sampled on the rising edge, dout valid the following cycle.
   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web) begin
            for (int i = 0; i < 4; i++)
               if (sram_wmask[i]) mem[sram_addr][8*i +: 8] = sram_din[8*i +: 8];
         end else begin
            sram_dout <= mem[sram_addr];
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (a_rvalid) begin
            if (q_a.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_rvalid: got rdata %h expected no response", a_rdata);
            end else begin
               check("a_rdata", a_rdata, q_a.pop_front());
            end
         end
         if (b_rvalid) begin
            if (q_b.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL b_unexpected_rvalid: got rdata %h expected no response", b_rdata);
            end else begin
               check("b_rdata", b_rdata, q_b.pop_front());
            end
         end
      end
   end

   // Holds A's request until accepted; returns 1 ns after the handshake edge.
   task automatic req_a(input logic we, input logic [3:0] wm, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input bit push);
      bit got;
      got = 0;
      a_valid = 1'b1; a_we = we; a_wmask = wm; a_addr = addr; a_wdata = wd;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (a_ready) got = 1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL a_handshake_timeout: got ready=0 expected ready=1 within 20 cycles");
      end else if (push && !we) begin
         q_a.push_back(exp_rd);
      end
      @(posedge clk); #1;
      a_valid = 1'b0;
   endtask

   task automatic req_b(input logic we, input logic [3:0] wm, input logic [11:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input bit push);
      bit got;
      got = 0;
      b_valid = 1'b1; b_we = we; b_wmask = wm; b_addr = addr; b_wdata = wd;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk);
         if (b_ready) got = 1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL b_handshake_timeout: got ready=0 expected ready=1 within 20 cycles");
      end else if (push && !we) begin
         q_b.push_back(exp_rd);
      end
      @(posedge clk); #1;
      b_valid = 1'b0;
   endtask

   initial begin
      logic [6:0]  rv_seen;
      logic [31:0] pipe_data [4];
      int na, nb;

      pipe_data[0] = 32'hC0DE_0000;
      pipe_data[1] = 32'hC0DE_1111;
      pipe_data[2] = 32'hC0DE_2222;
      pipe_data[3] = 32'hC0DE_3333;
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      for (int i = 0; i < 4; i++) mem[i] = pipe_data[i];
      for (int i = 0; i < 3; i++) begin
         mem[12'h100 + i] = 32'hAAAA_0000 + i;
         mem[12'h200 + i] = 32'hBBBB_0000 + i;
      end
      mem[12'h010] = 32'hDEAD_BEEF;
      mem[12'h011] = 32'h5555_AAAA;
      mem[12'h020] = 32'hFFFF_FFFF;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_csb", sram_csb, 1'b1);
      check("rst_web", sram_web, 1'b1);
      check("rst_addr", sram_addr, 12'h0);
      check("rst_din", sram_din, 32'h0);
      check("rst_wmask", sram_wmask, 4'h0);
      check("rst_ready", {a_ready, b_ready}, 2'b00);
      check("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
      check("rst_rdata", a_rdata | b_rdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Contention from reset: A, B, A, B, A, B
      na = 0; nb = 0;
      for (int i = 0; i < 6; i++) begin
         a_valid = 1'b1; a_we = 1'b0; a_addr = 12'h100 + 12'(na);
         b_valid = 1'b1; b_we = 1'b0; b_addr = 12'h200 + 12'(nb);
         @(negedge clk);
         check("contend_a_ready", a_ready, (i % 2 == 0));
         check("contend_b_ready", b_ready, (i % 2 == 1));
         if (a_ready) begin q_a.push_back(32'hAAAA_0000 + na); na++; end
         if (b_ready) begin q_b.push_back(32'hBBBB_0000 + nb); nb++; end
         @(posedge clk); #1;
      end
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("contend_a_drained", q_a.size(), 0);
      check("contend_b_drained", q_b.size(), 0);
`ifdef SRAM_ARB_PERF_EN
      check("perf_a_grant_cnt", a_grant_cnt, 32'd3);
      check("perf_b_grant_cnt", b_grant_cnt, 32'd3);
      check("perf_conflict_cnt", conflict_cnt, 32'd6);
`endif
      @(posedge clk); #1;

      // Single read by A
      req_a(1'b0, 4'h0, 12'h010, 32'h0, 32'hDEAD_BEEF, 1);
      @(negedge clk);
      check("single_csb_low", sram_csb, 1'b0);
      check("single_web_high", sram_web, 1'b1);
      check("single_addr", sram_addr, 12'h010);
      @(negedge clk);
      check("single_csb_release", sram_csb, 1'b1);
      check("single_no_early_rvalid", a_rvalid, 1'b0);
      @(negedge clk);
      check("single_a_rvalid", a_rvalid, 1'b1);
      check("single_b_rvalid", b_rvalid, 1'b0);
      @(posedge clk); #1;

      // B masked write, then A reads the same word
      req_b(1'b1, 4'b0011, 12'h020, 32'h1234_5678, 32'h0, 0);
      a_valid = 1'b1; a_we = 1'b0; a_addr = 12'h020;
      @(negedge clk);
      check("wr_csb", sram_csb, 1'b0);
      check("wr_web", sram_web, 1'b0);
      check("wr_wmask", sram_wmask, 4'b0011);
      check("wr_din", sram_din, 32'h1234_5678);
      check("wr_addr", sram_addr, 12'h020);
      check("rd_after_wr_ready", a_ready, 1'b1);
      if (a_ready) q_a.push_back(32'hFFFF_5678);
      @(posedge clk); #1;
      a_valid = 1'b0;
      @(negedge clk);
      check("rd_after_wr_web", sram_web, 1'b1);
      check("rd_after_wr_csb", sram_csb, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk); #1;

      // Back-to-back reads 0x000..0x003
      rv_seen = '0;
      for (int k = 0; k < 7; k++) begin
         if (k < 4) begin
            a_valid = 1'b1; a_we = 1'b0; a_addr = 12'(k);
         end else begin
            a_valid = 1'b0;
         end
         @(negedge clk);
         rv_seen[k] = a_rvalid;
         if (k < 4) begin
            check("pipe_a_ready", a_ready, 1'b1);
            if (a_ready) q_a.push_back(pipe_data[k]);
         end
         @(posedge clk); #1;
      end
      check("pipe_rvalid_pattern", 32'(rv_seen), 32'h78);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;

      // Reset one cycle after A's read handshake
      req_a(1'b0, 4'h0, 12'h011, 32'h0, 32'h0, 0);
      @(negedge clk);
      check("midrst_csb_before", sram_csb, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_csb_async", sram_csb, 1'b1);
`ifdef SRAM_ARB_PERF_EN
      check("midrst_perf_clear", a_grant_cnt | b_grant_cnt | conflict_cnt, 32'h0);
`endif
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("midrst_no_a_rvalid", a_rvalid, 1'b0);
      end

      check("final_q_a_empty", q_a.size(), 0);
      check("final_q_b_empty", q_b.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got no finish expected finish before 100000 ns");
      $fatal(1, "timeout");
   end

endmodule
